// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, twiddle Q format,
// and the round-half-up / saturate helpers used by butterfly output stages.
package fft_pkg;

  localparam int IL_DEF = 16;
  localparam int TW_DEF = 16;

  // Twiddles are Q1.(TW-1); products carry TW-1 fractional bits.
  function automatic int unsigned tw_qbits(input int unsigned tw);
    return tw - 1;
  endfunction

  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] x,
                                                 input int unsigned sh);
    logic signed [63:0] r;
    if (sh == 0) r = x;
    else         r = (x + (64'sd1 <<< (sh - 1))) >>> sh;
    return r;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      r = hi;
    else if (x < lo) r = lo;
    else             r = x;
    return r;
  endfunction

endpackage

// File: rtl/bf_cmul.sv
// Registered full-precision complex multiply P = D*W with a bypass that
// treats W as exactly +1 (D aligned to the Q(TW-1) product scale).
module bf_cmul
  import fft_pkg::*;
#(
  parameter int DW = 17,
  parameter int TW = 16,
  parameter int PW = DW + TW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] d_re,
  input  logic signed [DW-1:0] d_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  input  logic                 byp,
  output logic signed [PW-1:0] p_re,
  output logic signed [PW-1:0] p_im
);

  localparam int MW = DW + TW;
  localparam int QB = tw_qbits(TW);

  logic signed [MW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] m_re, m_im, b_re, b_im;

  assign rr = MW'(d_re) * MW'(w_re);
  assign ii = MW'(d_im) * MW'(w_im);
  assign ri = MW'(d_re) * MW'(w_im);
  assign ir = MW'(d_im) * MW'(w_re);

  // One extra bit over the product width keeps (-1)*(-1) terms exact.
  assign m_re = PW'(rr) - PW'(ii);
  assign m_im = PW'(ri) + PW'(ir);
  assign b_re = PW'(d_re) <<< QB;
  assign b_im = PW'(d_im) <<< QB;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_re <= '0;
      p_im <= '0;
    end else if (en) begin
      p_re <= byp ? b_re : m_re;
      p_im <= byp ? b_im : m_im;
    end
  end

endmodule

// File: rtl/bf_r2_pipe.sv
// Three-stage complex radix-2 DIF butterfly: A = a+b, D = (a-b)*W, with
// per-sample scale/bypass, round-half-up, saturation and sticky overflow.
module bf_r2_pipe
  import fft_pkg::*;
#(
  parameter int IL = IL_DEF,
  parameter int TW = TW_DEF,
  parameter int OL = IL + 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iEN,
  input  logic                 iVALID,
  input  logic signed [IL-1:0] iDATA1_re,
  input  logic signed [IL-1:0] iDATA1_im,
  input  logic signed [IL-1:0] iDATA2_re,
  input  logic signed [IL-1:0] iDATA2_im,
  input  logic signed [TW-1:0] iTW_re,
  input  logic signed [TW-1:0] iTW_im,
  input  logic                 iTW_BYP,
  input  logic                 iSCALE,
  input  logic                 iCLR_OVF,
  output logic                 oVALID,
  output logic signed [OL-1:0] oDATA_add_re,
  output logic signed [OL-1:0] oDATA_add_im,
  output logic signed [OL-1:0] oDATA_sub_re,
  output logic signed [OL-1:0] oDATA_sub_im,
  output logic                 oOVF
);

  localparam int SW = IL + 1;
  localparam int PW = IL + TW + 2;
  localparam int QB = tw_qbits(TW);

  logic signed [SW-1:0] s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
  logic signed [TW-1:0] s1_w_re, s1_w_im;
  logic                 s1_byp, s1_scl, s1_vld;

  logic signed [SW-1:0] s2_sum_re, s2_sum_im;
  logic signed [PW-1:0] s2_p_re, s2_p_im;
  logic                 s2_scl, s2_vld;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_sum_re <= '0;
      s1_sum_im <= '0;
      s1_dif_re <= '0;
      s1_dif_im <= '0;
      s1_w_re   <= '0;
      s1_w_im   <= '0;
      s1_byp    <= 1'b0;
      s1_scl    <= 1'b0;
      s1_vld    <= 1'b0;
    end else if (iEN) begin
      s1_sum_re <= SW'(iDATA1_re) + SW'(iDATA2_re);
      s1_sum_im <= SW'(iDATA1_im) + SW'(iDATA2_im);
      s1_dif_re <= SW'(iDATA1_re) - SW'(iDATA2_re);
      s1_dif_im <= SW'(iDATA1_im) - SW'(iDATA2_im);
      s1_w_re   <= iTW_re;
      s1_w_im   <= iTW_im;
      s1_byp    <= iTW_BYP;
      s1_scl    <= iSCALE;
      s1_vld    <= iVALID;
    end
  end

  bf_cmul #(.DW(SW), .TW(TW), .PW(PW)) u_cmul (
    .clk  (iCLK),
    .rst  (iRST),
    .en   (iEN),
    .d_re (s1_dif_re),
    .d_im (s1_dif_im),
    .w_re (s1_w_re),
    .w_im (s1_w_im),
    .byp  (s1_byp),
    .p_re (s2_p_re),
    .p_im (s2_p_im)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s2_sum_re <= '0;
      s2_sum_im <= '0;
      s2_scl    <= 1'b0;
      s2_vld    <= 1'b0;
    end else if (iEN) begin
      s2_sum_re <= s1_sum_re;
      s2_sum_im <= s1_sum_im;
      s2_scl    <= s1_scl;
      s2_vld    <= s1_vld;
    end
  end

  logic signed [63:0] r_add_re, r_add_im, r_sub_re, r_sub_im;
  logic signed [63:0] q_add_re, q_add_im, q_sub_re, q_sub_im;
  logic               sat_any;

  assign r_add_re = rnd_shr(64'(s2_sum_re), 32'(s2_scl));
  assign r_add_im = rnd_shr(64'(s2_sum_im), 32'(s2_scl));
  assign r_sub_re = rnd_shr(64'(s2_p_re), QB + 32'(s2_scl));
  assign r_sub_im = rnd_shr(64'(s2_p_im), QB + 32'(s2_scl));

  assign q_add_re = sat(r_add_re, OL);
  assign q_add_im = sat(r_add_im, OL);
  assign q_sub_re = sat(r_sub_re, OL);
  assign q_sub_im = sat(r_sub_im, OL);

  assign sat_any = (q_add_re != r_add_re) || (q_add_im != r_add_im) ||
                   (q_sub_re != r_sub_re) || (q_sub_im != r_sub_im);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDATA_add_re <= '0;
      oDATA_add_im <= '0;
      oDATA_sub_re <= '0;
      oDATA_sub_im <= '0;
      oVALID       <= 1'b0;
    end else if (iEN) begin
      oDATA_add_re <= q_add_re[OL-1:0];
      oDATA_add_im <= q_add_im[OL-1:0];
      oDATA_sub_re <= q_sub_re[OL-1:0];
      oDATA_sub_im <= q_sub_im[OL-1:0];
      oVALID       <= s2_vld;
    end
  end

  // Set has priority over clear; clear is honoured even while stalled.
  always_ff @(posedge iCLK) begin
    if (iRST)                           oOVF <= 1'b0;
    else if (iEN && s2_vld && sat_any)  oOVF <= 1'b1;
    else if (iCLR_OVF)                  oOVF <= 1'b0;
  end

endmodule

// File: tb/tb_bf_r2_pipe.sv
// Directed bench for bf_r2_pipe (IL=16, TW=16) with hand-computed results.
module tb_bf_r2_pipe;

  logic        iCLK = 1'b0;
  logic        iRST, iEN, iVALID, iTW_BYP, iSCALE, iCLR_OVF;
  logic [15:0] iDATA1_re, iDATA1_im, iDATA2_re, iDATA2_im, iTW_re, iTW_im;
  logic        oVALID, oOVF;
  logic [16:0] oDATA_add_re, oDATA_add_im, oDATA_sub_re, oDATA_sub_im;

  int checks = 0;
  int errors = 0;
  int nxt    = 0;

  always #5 iCLK = ~iCLK;

  bf_r2_pipe #(.IL(16), .TW(16), .OL(17)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iVALID(iVALID),
    .iDATA1_re(iDATA1_re), .iDATA1_im(iDATA1_im),
    .iDATA2_re(iDATA2_re), .iDATA2_im(iDATA2_im),
    .iTW_re(iTW_re), .iTW_im(iTW_im),
    .iTW_BYP(iTW_BYP), .iSCALE(iSCALE), .iCLR_OVF(iCLR_OVF),
    .oVALID(oVALID),
    .oDATA_add_re(oDATA_add_re), .oDATA_add_im(oDATA_add_im),
    .oDATA_sub_re(oDATA_sub_re), .oDATA_sub_im(oDATA_sub_im),
    .oOVF(oOVF)
  );

  function automatic int sx(input logic [16:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input int byp, input int scl,
                       input int vld);
    iDATA1_re = ar[15:0];
    iDATA1_im = ai[15:0];
    iDATA2_re = br[15:0];
    iDATA2_im = bi[15:0];
    iTW_re    = wr[15:0];
    iTW_im    = wi[15:0];
    iTW_BYP   = byp[0];
    iSCALE    = scl[0];
    iVALID    = vld[0];
  endtask

  task automatic chk_out(input string tag, input int ar, input int ai,
                         input int sr, input int si);
    chk({tag, "_vld"}, int'(oVALID), 1);
    chk({tag, "_add_re"}, sx(oDATA_add_re), ar);
    chk({tag, "_add_im"}, sx(oDATA_add_im), ai);
    chk({tag, "_sub_re"}, sx(oDATA_sub_re), sr);
    chk({tag, "_sub_im"}, sx(oDATA_sub_im), si);
  endtask

  // Stream sample i: a=(10i+5, i-3), b=(i, 2), bypass, no scale.
  task automatic collect();
    if (oVALID) begin
      chk("strm_add_re", sx(oDATA_add_re), 11 * nxt + 5);
      chk("strm_add_im", sx(oDATA_add_im), nxt - 1);
      chk("strm_sub_re", sx(oDATA_sub_re), 9 * nxt + 5);
      chk("strm_sub_im", sx(oDATA_sub_im), nxt - 5);
      nxt++;
    end
  endtask

  initial begin
    iRST = 1'b1; iEN = 1'b1; iCLR_OVF = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_vld", int'(oVALID), 0);
    chk("rst_ovf", int'(oOVF), 0);
    chk("rst_add_re", sx(oDATA_add_re), 0);
    chk("rst_sub_im", sx(oDATA_sub_im), 0);
    iRST = 1'b0;

    // Bypass add/sub
    drive(100, 50, 30, -20, 0, 0, 1, 0, 1);
    tick();
    iVALID = 1'b0;
    tick();
    chk("lat_vld", int'(oVALID), 0);
    tick();
    chk_out("byp", 130, 30, 70, 70);
    chk("byp_ovf", int'(oOVF), 0);

    // W = -j
    drive(100, 50, 30, -20, 0, -32768, 0, 0, 1);
    tick();
    iVALID = 1'b0;
    tick(); tick();
    chk_out("mj", 130, 30, 70, -70);

    // Saturation with W = (-1,-1)
    drive(32767, 32767, -32768, -32768, -32768, -32768, 0, 0, 1);
    tick();
    iVALID = 1'b0;
    tick(); tick();
    chk_out("sat", -1, -1, 0, -65536);
    chk("sat_ovf", int'(oOVF), 1);
    repeat (5) tick();
    chk("sat_idle_vld", int'(oVALID), 0);
    chk("sat_sticky", int'(oOVF), 1);
    iCLR_OVF = 1'b1;
    tick();
    iCLR_OVF = 1'b0;
    chk("ovf_clr", int'(oOVF), 0);

    // Scale then no-scale, back to back
    drive(3, 0, 0, 0, 0, 0, 1, 1, 1);
    tick();
    drive(-3, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    iVALID = 1'b0;
    tick();
    chk_out("scl1", 2, 0, 2, 0);
    tick();
    chk_out("scl0", -3, 0, -3, 0);
    repeat (3) tick();

    // Stream of 6 with a 2-cycle stall after the third
    nxt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        iEN = 1'b0;
        drive(30000, 30000, -30000, -30000, 0, 0, 1, 1, 1);
        for (int s = 0; s < 2; s++) begin
          tick();
          chk("stall_vld", int'(oVALID), 1);
          chk("stall_add_re", sx(oDATA_add_re), 11 * (nxt - 1) + 5);
          chk("stall_sub_im", sx(oDATA_sub_im), (nxt - 1) - 5);
        end
        iEN = 1'b1;
      end
      drive(10 * i + 5, i - 3, i, 2, 0, 0, 1, 0, 1);
      tick();
      collect();
    end
    iVALID = 1'b0;
    for (int c = 0; c < 12 && nxt < 6; c++) begin
      tick();
      collect();
    end
    chk("strm_count", nxt, 6);
    tick();
    chk("strm_drained", int'(oVALID), 0);

    // Set and clear in the same cycle: set wins
    drive(32767, 32767, -32768, -32768, -32768, -32768, 0, 0, 1);
    tick();
    iVALID = 1'b0;
    tick();
    iCLR_OVF = 1'b1;
    tick();
    iCLR_OVF = 1'b0;
    chk("set_wins", int'(oOVF), 1);

    // Reset with samples in flight and oOVF set
    drive(1, 1, 0, 0, 0, 0, 1, 0, 1);
    tick(); tick(); tick();
    chk("pre_rst_vld", int'(oVALID), 1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("mrst_vld", int'(oVALID), 0);
    chk("mrst_ovf", int'(oOVF), 0);
    chk("mrst_add_re", sx(oDATA_add_re), 0);
    chk("mrst_sub_re", sx(oDATA_sub_re), 0);
    drive(7, 8, 1, 1, 0, 0, 1, 0, 1);
    tick();
    iVALID = 1'b0;
    chk("post_rst_l1", int'(oVALID), 0);
    tick();
    chk("post_rst_l2", int'(oVALID), 0);
    tick();
    chk_out("post_rst", 8, 9, 6, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_r2_pipe.md
Name: bf_r2_pipe

Overview:
- Pipelined, parametrised complex radix-2 DIF butterfly.
- Computes A = a+b and D = (a−b)·W, with optional twiddle bypass, runtime 1-bit scaling, rounding, saturation and a sticky overflow flag.
- Carries a valid bit alongside the data and supports a global stall.
- Successor to the plain real add/sub butterfly; one instance per stage of the 16-point pipelined FFT datapath.

Parameters:
- IL, 16: input component width (two's complement, per real/imag part).
- TW, 16: twiddle component width, Q1.(TW−1) signed.
- OL, IL+1: output component width.

Ports:
- iCLK  input  1  clock, rising edge.
- iRST  input  1  synchronous reset, active-high.
- iEN  input  1  pipeline enable; 0 freezes every register.
- iVALID  input  1  input sample valid.
- iDATA1_re, iDATA1_im  input  IL each  operand a.
- iDATA2_re, iDATA2_im  input  IL each  operand b.
- iTW_re, iTW_im  input  TW each  twiddle W.
- iTW_BYP  input  1  1: W treated as exactly +1 (no multiply).
- iSCALE  input  1  1: both outputs divided by 2 with rounding.
- iCLR_OVF  input  1  clears oOVF.
- oVALID  output  1  output valid.
- oDATA_add_re, oDATA_add_im  output  OL each  A.
- oDATA_sub_re, oDATA_sub_im  output  OL each  D.
- oOVF  output  1  sticky saturation flag.

Behaviour:
- Reset: iRST=1 at a rising edge clears all pipeline registers, valid bits and oOVF to 0. Reset overrides iEN. A reset mid-stream discards all in-flight samples; oVALID=0 from the next cycle.
- Pipeline: 3 register stages, latency 3 enabled cycles.
  - S1: register IL+1-bit sign-extended sum and difference per component; register W, iTW_BYP, iSCALE and iVALID.
  - S2: complex multiply of D by W at full precision.
    - P_re = Dr·Wr − Di·Wi, P_im = Dr·Wi + Di·Wr, each IL+TW+2 bits.
    - If bypass, P = D << (TW−1).
    - Sum path delayed one stage to stay aligned.
  - S3: shift P right by TW−1, plus 1 more if the scale bit is set, rounding half-up (add 1 at the dropped MSB position, then arithmetic shift).
    - Sum path: shifted by 1 with the same rounding only if scaled.
    - Saturate each component to OL bits (min −2^(OL−1), max 2^(OL−1)−1) and register.
- Mode capture: iSCALE and iTW_BYP are sampled with their data and travel down the pipe, so mode changes between samples are exact per-sample.
- Enable and stall: iEN=0 holds all stages, oVALID and outputs, and no sample is lost or duplicated. iVALID is ignored while iEN=0.
- Valid: oVALID follows iVALID with latency 3. Data registers load regardless of valid, but oOVF only sets on saturation of a valid sample.
- oOVF: set when any component of a valid S3 result saturates. It stays set until iCLR_OVF or reset. If set and clear happen in the same cycle, set wins.
- W = −1 (0x8000 per component) is legal and must not overflow internally.

Decomposition:
- Shared package fft_pkg holds:
  - default widths IL/TW;
  - the twiddle Q-format constant (TW−1);
  - round-half-up and saturate functions, used by S3 and by later FFT stages.
- One natural sub-module, bf_cmul: registered complex multiplier implementing the S2 multiply and the bypass mux.

Test Plan (IL=16, TW=16):
- Bypass add/sub: a=(100,50), b=(30,−20), iTW_BYP=1, iSCALE=0, iVALID=1 → 3 cycles later oVALID=1, add=(130,30), sub=(70,70), oOVF=0.
- Twiddle −j: same a/b, W=(0, 0x8000), bypass 0 → sub=(70,−70), add=(130,30).
- Saturation: a=(32767,32767), b=(−32768,−32768), W=(0x8000,0x8000) → sub=(0,−65536) saturated, oOVF=1 and still 1 after 5 idle cycles; iCLR_OVF pulse → 0 next cycle.
- Scaling and rounding, back-to-back samples:
  - a=(3,0), b=0, iSCALE=1, bypass → add=(2,0), sub=(2,0).
  - next a=(−3,0), iSCALE=0 → add=(−3,0), sub=(−3,0); confirms per-sample mode.
- Stall: stream 6 valid samples, iEN=0 for 2 cycles mid-stream → outputs and oVALID frozen during the stall, all 6 results emerge in order with none dropped.
- Reset mid-stream: iRST=1 with 3 samples in flight and oOVF set → next cycle oVALID=0, all outputs 0, oOVF=0; first post-reset sample appears 3 cycles after issue.
